// File: rtl/fpu_align_ctrl_pkg.sv
// Shared FPU alignment definitions: shifter mode codes and controller state encoding.
package fpu_align_ctrl_pkg;

    localparam logic [1:0] AGREATER = 2'b10;
    localparam logic [1:0] BGREATER = 2'b00;
    localparam logic [1:0] EQUAL    = 2'b11;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CFG    = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

endpackage

// File: rtl/fpu_align_ctrl_if.sv
// Operand/result bundle between the FPU front end and the alignment controller.
interface fpu_align_ctrl_if #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      sign_a;
    logic                      sign_b;
    logic [EXP_WIDTH-1:0]      exp_a;
    logic [EXP_WIDTH-1:0]      exp_b;
    logic [MANTISSA_WIDTH-1:0] man_a;
    logic [MANTISSA_WIDTH-1:0] man_b;
    logic                      op_sub;
    logic [MANTISSA_WIDTH-1:0] ma;
    logic [MANTISSA_WIDTH-1:0] mb;
    logic [1:0]                exp_magnitude;
    logic [4:0]                shift_spaces;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_WIDTH-1:0]      exp_res;
    logic                      sign_res;
    logic                      eff_sub;

    modport master (
        output in_valid, sign_a, sign_b, exp_a, exp_b, man_a, man_b, op_sub, out_ready,
        input  in_ready, ma, mb, exp_magnitude, shift_spaces, out_valid, exp_res, sign_res, eff_sub
    );

    modport slave (
        input  in_valid, sign_a, sign_b, exp_a, exp_b, man_a, man_b, op_sub, out_ready,
        output in_ready, ma, mb, exp_magnitude, shift_spaces, out_valid, exp_res, sign_res, eff_sub
    );
endinterface

// File: rtl/fpu_align_ctrl_exp_compare.sv
// Unsigned exponent compare: shifter mode, saturated shift distance and larger exponent.
module exp_compare
    import fpu_align_ctrl_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int AW        = 27
) (
    input  logic [EXP_WIDTH-1:0] exp_a,
    input  logic [EXP_WIDTH-1:0] exp_b,
    output logic [1:0]           exp_magnitude,
    output logic [4:0]           shift_spaces,
    output logic [EXP_WIDTH-1:0] exp_max
);
    logic [EXP_WIDTH-1:0] diff;

    always_comb begin
        exp_magnitude = EQUAL;
        diff          = '0;
        exp_max       = exp_a;
        if (exp_a > exp_b) begin
            exp_magnitude = AGREATER;
            diff          = exp_a - exp_b;
        end else if (exp_b > exp_a) begin
            exp_magnitude = BGREATER;
            diff          = exp_b - exp_a;
            exp_max       = exp_b;
        end
        // Anything at or beyond the aligned width shifts the operand out entirely.
        if (diff >= EXP_WIDTH'(AW))
            shift_spaces = 5'(AW);
        else
            shift_spaces = 5'(diff);
    end
endmodule

// File: rtl/fpu_align_ctrl.sv
// Alignment controller: captures an operand pair and holds shifter config stable until the adder accepts.
module fpu_align_ctrl
    import fpu_align_ctrl_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic             clk,
    input  logic             arst,
    fpu_align_ctrl_if.slave  bus
);
    localparam int AW = MANTISSA_WIDTH + 4;

    logic [1:0]                state;
    logic [1:0]                cmp_mag;
    logic [4:0]                cmp_shift;
    logic [EXP_WIDTH-1:0]      cmp_max;
    logic                      handshake;

    logic [MANTISSA_WIDTH-1:0] ma_q;
    logic [MANTISSA_WIDTH-1:0] mb_q;
    logic [1:0]                mag_q;
    logic [4:0]                shift_q;
    logic [EXP_WIDTH-1:0]      exp_res_q;
    logic                      sign_res_q;
    logic                      eff_sub_q;

    exp_compare #(
        .EXP_WIDTH (EXP_WIDTH),
        .AW        (AW)
    ) u_exp_compare (
        .exp_a         (bus.exp_a),
        .exp_b         (bus.exp_b),
        .exp_magnitude (cmp_mag),
        .shift_spaces  (cmp_shift),
        .exp_max       (cmp_max)
    );

    assign handshake = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            ma_q       <= '0;
            mb_q       <= '0;
            mag_q      <= '0;
            shift_q    <= '0;
            exp_res_q  <= '0;
            sign_res_q <= 1'b0;
            eff_sub_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        ma_q       <= bus.man_a;
                        mb_q       <= bus.man_b;
                        mag_q      <= cmp_mag;
                        shift_q    <= cmp_shift;
                        exp_res_q  <= cmp_max;
                        eff_sub_q  <= bus.sign_a ^ bus.sign_b ^ bus.op_sub;
                        sign_res_q <= (cmp_mag == BGREATER) ? (bus.sign_b ^ bus.op_sub) : bus.sign_a;
                        state      <= CFG;
                    end
                end
                CFG:     state <= SETTLE;
                SETTLE:  state <= HOLD;
                HOLD:    if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == HOLD);
    assign bus.ma            = ma_q;
    assign bus.mb            = mb_q;
    assign bus.exp_magnitude = mag_q;
    assign bus.shift_spaces  = shift_q;
    assign bus.exp_res       = exp_res_q;
    assign bus.sign_res      = sign_res_q;
    assign bus.eff_sub       = eff_sub_q;
endmodule

// File: tb/tb_fpu_align_ctrl.sv
// Directed bench for the FPU alignment controller with hand-computed expectations.
module tb_fpu_align_ctrl;
    logic clk;
    logic arst;
    int   errors = 0;
    int   checks = 0;

    fpu_align_ctrl_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

    fpu_align_ctrl #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [22:0] fa, input logic [22:0] fb, input logic sub);
        bus.sign_a = sa;
        bus.sign_b = sb;
        bus.exp_a  = ea;
        bus.exp_b  = eb;
        bus.man_a  = fa;
        bus.man_b  = fb;
        bus.op_sub = sub;
    endtask

    task automatic chk_result(input string tag, input logic [1:0] mag, input logic [4:0] sh,
                              input logic [7:0] er, input logic sr, input logic es);
        chk({tag, ".mag"},      32'(bus.exp_magnitude), 32'(mag));
        chk({tag, ".shift"},    32'(bus.shift_spaces),  32'(sh));
        chk({tag, ".exp_res"},  32'(bus.exp_res),       32'(er));
        chk({tag, ".sign_res"}, 32'(bus.sign_res),      32'(sr));
        chk({tag, ".eff_sub"},  32'(bus.eff_sub),       32'(es));
    endtask

    logic [7:0] bb_ea [3] = '{8'd10, 8'd3, 8'd77};
    logic [7:0] bb_eb [3] = '{8'd3, 8'd40, 8'd77};
    logic [7:0] bb_res[3] = '{8'd10, 8'd40, 8'd77};
    logic [4:0] bb_sh [3] = '{5'd7, 5'd27, 5'd0};
    logic [1:0] bb_mag[3] = '{2'b10, 2'b00, 2'b11};

    initial begin
        arst          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load(0, 0, 8'd0, 8'd0, 23'd0, 23'd0, 0);

        // Reset state
        step();
        step();
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.ma",        32'(bus.ma),        32'd0);
        chk_result("rst", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
        arst = 1'b0;
        step();

        // A greater by 3, add
        load(1, 0, 8'd130, 8'd127, 23'h400000, 23'h123456, 0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk("t1.in_ready_idle", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t1.c1.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1.c1.in_ready",  32'(bus.in_ready),  32'd0);
        chk_result("t1.cfg", 2'b10, 5'd3, 8'd130, 1'b1, 1'b1);
        step();
        chk("t1.c2.out_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("t1.c3.out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1.ma", 32'(bus.ma), 32'h400000);
        chk("t1.mb", 32'(bus.mb), 32'h123456);
        chk_result("t1.hold", 2'b10, 5'd3, 8'd130, 1'b1, 1'b1);
        step();
        chk("t1.c4.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1.c4.in_ready",  32'(bus.in_ready),  32'd1);

        // B greater by 100, saturated shift
        load(0, 0, 8'd100, 8'd200, 23'h000001, 23'h7fffff, 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("t2.out_valid", 32'(bus.out_valid), 32'd1);
        chk_result("t2", 2'b00, 5'd27, 8'd200, 1'b1, 1'b1);
        step();

        // Equal exponents, subtract of like signs
        load(0, 0, 8'd127, 8'd127, 23'h2aaaaa, 23'h155555, 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("t3.out_valid", 32'(bus.out_valid), 32'd1);
        chk_result("t3", 2'b11, 5'd0, 8'd127, 1'b0, 1'b1);
        step();

        // Shift boundaries: distance 26 stays, distance 255 saturates
        load(0, 1, 8'd153, 8'd127, 23'd5, 23'd6, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk_result("t4.d26", 2'b10, 5'd26, 8'd153, 1'b0, 1'b1);
        step();
        load(1, 0, 8'd0, 8'd255, 23'd5, 23'd6, 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk_result("t4.d255", 2'b00, 5'd27, 8'd255, 1'b1, 1'b0);
        step();

        // Backpressure in HOLD; in_valid offered meanwhile must be ignored
        load(1, 1, 8'd5, 8'd30, 23'h0abcde, 23'h654321, 0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        load(0, 1, 8'd200, 8'd1, 23'd1, 23'd2, 1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5.hold.out_valid", 32'(bus.out_valid), 32'd1);
            chk("t5.hold.in_ready",  32'(bus.in_ready),  32'd0);
            chk("t5.hold.ma",        32'(bus.ma),        32'h0abcde);
            chk("t5.hold.mb",        32'(bus.mb),        32'h654321);
            chk_result("t5.hold", 2'b00, 5'd25, 8'd30, 1'b1, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t5.rel.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5.rel.in_ready",  32'(bus.in_ready),  32'd1);
        chk("t5.rel.exp_res",   32'(bus.exp_res),   32'd30);
        step();

        // Asynchronous reset during SETTLE
        load(0, 0, 8'd140, 8'd120, 23'h3fffff, 23'h1, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        arst = 1'b1;
        #1;
        chk("t6.in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.ma",        32'(bus.ma),        32'd0);
        chk_result("t6", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
        #2;
        arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6.post.out_valid", 32'(bus.out_valid), 32'd0);
        end
        load(1, 1, 8'd154, 8'd127, 23'h111111, 23'h222222, 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("t6.next.out_valid", 32'(bus.out_valid), 32'd1);
        chk_result("t6.next", 2'b10, 5'd27, 8'd154, 1'b1, 1'b1);
        step();

        // Back-to-back with in_valid held high
        load(0, 0, bb_ea[0], bb_eb[0], 23'd1, 23'd2, 0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk("t7.in_ready",  32'(bus.in_ready),  32'((cyc % 4) == 0));
            chk("t7.out_valid", 32'(bus.out_valid), 32'((cyc % 4) == 3));
            if ((cyc % 4) == 3) begin
                chk("t7.exp_res", 32'(bus.exp_res),       32'(bb_res[cyc / 4]));
                chk("t7.shift",   32'(bus.shift_spaces),  32'(bb_sh[cyc / 4]));
                chk("t7.mag",     32'(bus.exp_magnitude), 32'(bb_mag[cyc / 4]));
            end
            step();
            if ((cyc % 4) == 0) begin
                if (cyc / 4 < 2)
                    load(0, 0, bb_ea[cyc / 4 + 1], bb_eb[cyc / 4 + 1], 23'd1, 23'd2, 0);
                else
                    bus.in_valid = 1'b0;
            end
        end
        chk("t7.end.in_ready", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
